// File: rtl/spi_apb_arbiter.sv
// Two-requester round-robin arbiter in front of a single APB-style register port
// (the SPI controller). One transfer at a time: IDLE arbitrates, BUSY holds the
// slave access until pready_i or a cycle timeout, RESP pulses the owner's pready.
module spi_apb_arbiter #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                  pclk_i,
  input  logic                  prst_i,
  // requester 0
  input  logic [ADDR_WIDTH-1:0] m0_paddr_i,
  input  logic                  m0_pwrite_i,
  input  logic [DATA_WIDTH-1:0] m0_pwdata_i,
  input  logic                  m0_penable_i,
  output logic [DATA_WIDTH-1:0] m0_prdata_o,
  output logic                  m0_pready_o,
  output logic                  m0_perror_o,
  // requester 1
  input  logic [ADDR_WIDTH-1:0] m1_paddr_i,
  input  logic                  m1_pwrite_i,
  input  logic [DATA_WIDTH-1:0] m1_pwdata_i,
  input  logic                  m1_penable_i,
  output logic [DATA_WIDTH-1:0] m1_prdata_o,
  output logic                  m1_pready_o,
  output logic                  m1_perror_o,
  // shared slave port
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic                  pwrite_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  output logic                  penable_o,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pready_i,
  input  logic                  perror_i,
  output logic [1:0]            grant_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Counter value seen on the last allowed BUSY cycle.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [1:0]            state_q, state_d;
  logic                  owner_q, owner_d;   // 0 = m0, 1 = m1
  logic                  last_q, last_d;     // requester served most recently
  logic [7:0]            cnt_q, cnt_d;
  logic [1:0]            grant_q, grant_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  penable_q, penable_d;
  logic [DATA_WIDTH-1:0] m0_prdata_q, m0_prdata_d;
  logic [DATA_WIDTH-1:0] m1_prdata_q, m1_prdata_d;
  logic                  m0_pready_q, m0_pready_d;
  logic                  m1_pready_q, m1_pready_d;
  logic                  m0_perror_q, m0_perror_d;
  logic                  m1_perror_q, m1_perror_d;

  logic                  pick_m1;
  logic                  timeout_hit;
  logic                  xfer_done;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;

  // On a tie the requester that was not served last wins.
  assign pick_m1     = m1_penable_i & (~m0_penable_i | ~last_q);
  assign timeout_hit = (cnt_q == TO_LAST);
  // pready_i takes priority over a coincident timeout.
  assign xfer_done   = pready_i | timeout_hit;
  assign rsp_data    = (pready_i && !pwrite_q) ? prdata_i : '0;
  assign rsp_err     = pready_i ? perror_i : 1'b1;

  // Next-state and output-register logic for the IDLE/BUSY/RESP sequence.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    penable_d   = penable_q;
    m0_prdata_d = m0_prdata_q;
    m1_prdata_d = m1_prdata_q;
    m0_pready_d = 1'b0;
    m1_pready_d = 1'b0;
    m0_perror_d = 1'b0;
    m1_perror_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (m0_penable_i || m1_penable_i) begin
          owner_d   = pick_m1;
          grant_d   = pick_m1 ? 2'b10 : 2'b01;
          paddr_d   = pick_m1 ? m1_paddr_i  : m0_paddr_i;
          pwrite_d  = pick_m1 ? m1_pwrite_i : m0_pwrite_i;
          pwdata_d  = pick_m1 ? m1_pwdata_i : m0_pwdata_i;
          penable_d = 1'b1;
          cnt_d     = '0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (xfer_done) begin
          penable_d = 1'b0;
          state_d   = RESP;
          if (owner_q) begin
            m1_prdata_d = rsp_data;
            m1_pready_d = 1'b1;
            m1_perror_d = rsp_err;
          end else begin
            m0_prdata_d = rsp_data;
            m0_pready_d = 1'b1;
            m0_perror_d = rsp_err;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        grant_d = 2'b00;
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any transfer in flight without a completion.
  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      grant_q     <= 2'b00;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      penable_q   <= 1'b0;
      m0_prdata_q <= '0;
      m1_prdata_q <= '0;
      m0_pready_q <= 1'b0;
      m1_pready_q <= 1'b0;
      m0_perror_q <= 1'b0;
      m1_perror_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      penable_q   <= penable_d;
      m0_prdata_q <= m0_prdata_d;
      m1_prdata_q <= m1_prdata_d;
      m0_pready_q <= m0_pready_d;
      m1_pready_q <= m1_pready_d;
      m0_perror_q <= m0_perror_d;
      m1_perror_q <= m1_perror_d;
    end
  end

  assign paddr_o     = paddr_q;
  assign pwrite_o    = pwrite_q;
  assign pwdata_o    = pwdata_q;
  assign penable_o   = penable_q;
  assign grant_o     = grant_q;
  assign m0_prdata_o = m0_prdata_q;
  assign m1_prdata_o = m1_prdata_q;
  assign m0_pready_o = m0_pready_q;
  assign m1_pready_o = m1_pready_q;
  assign m0_perror_o = m0_perror_q;
  assign m1_perror_o = m1_perror_q;

endmodule

// File: tb/tb_spi_apb_arbiter.sv
// Bench for spi_apb_arbiter: a driver issues requests and plays the slave,
// pushing the expected completion into a scoreboard; a monitor pops and checks
// every requester completion and the held read data.
module tb_spi_apb_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 64;

  typedef struct packed {
    logic          m;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  logic          pclk = 1'b0;
  logic          prst;
  logic [AW-1:0] m_addr  [2];
  logic          m_wr    [2];
  logic [DW-1:0] m_wdata [2];
  logic          m_en    [2];
  logic [DW-1:0] m0_prdata_o, m1_prdata_o;
  logic          m0_pready_o, m1_pready_o, m0_perror_o, m1_perror_o;
  logic [AW-1:0] paddr_o;
  logic          pwrite_o, penable_o;
  logic [DW-1:0] pwdata_o;
  logic [DW-1:0] prdata_i;
  logic          pready_i, perror_i;
  logic [1:0]    grant_o;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   rr_last = 1'b1;   // model: requester served last (1 = m1)
  bit   done    = 1'b0;

  spi_apb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .pclk_i      (pclk),
    .prst_i      (prst),
    .m0_paddr_i  (m_addr[0]),
    .m0_pwrite_i (m_wr[0]),
    .m0_pwdata_i (m_wdata[0]),
    .m0_penable_i(m_en[0]),
    .m0_prdata_o (m0_prdata_o),
    .m0_pready_o (m0_pready_o),
    .m0_perror_o (m0_perror_o),
    .m1_paddr_i  (m_addr[1]),
    .m1_pwrite_i (m_wr[1]),
    .m1_pwdata_i (m_wdata[1]),
    .m1_penable_i(m_en[1]),
    .m1_prdata_o (m1_prdata_o),
    .m1_pready_o (m1_pready_o),
    .m1_perror_o (m1_perror_o),
    .paddr_o     (paddr_o),
    .pwrite_o    (pwrite_o),
    .pwdata_o    (pwdata_o),
    .penable_o   (penable_o),
    .prdata_i    (prdata_i),
    .pready_i    (pready_i),
    .perror_i    (perror_i),
    .grant_o     (grant_o)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic randomize_req(input int m);
    m_addr[m]  = AW'($urandom);
    m_wr[m]    = 1'($urandom_range(0, 1));
    m_wdata[m] = DW'($urandom);
  endtask

  // Serve n0 transfers for m0 and n1 for m1. lat_fix > 0 fixes the slave
  // latency in BUSY cycles (TO+1 means the slave never answers); rd_fix >= 0
  // fixes the slave read data.
  task automatic run_batch(input int n0, input int n1, input int lat_fix, input int rd_fix);
    int            rem [2];
    int            w;
    int            lat;
    bit            seen;
    bit            stable;
    logic [AW-1:0] ea;
    logic          ew;
    logic [DW-1:0] ewd;
    logic [DW-1:0] rd;
    logic          er;
    logic [1:0]    eg;
    exp_t          e;
    rem[0]  = n0;
    rem[1]  = n1;
    m_en[0] = (n0 > 0);
    m_en[1] = (n1 > 0);
    while (rem[0] > 0 || rem[1] > 0) begin
      if (rem[0] > 0 && rem[1] > 0) w = rr_last ? 0 : 1;
      else w = (rem[0] > 0) ? 0 : 1;
      ea  = m_addr[w];
      ew  = m_wr[w];
      ewd = m_wdata[w];
      eg  = (w == 1) ? 2'b10 : 2'b01;
      seen = 1'b0;
      // Slave noise outside BUSY must be ignored.
      for (int i = 0; i < 8 && !seen; i++) begin
        pready_i = 1'($urandom_range(0, 1));
        prdata_i = DW'($urandom);
        perror_i = 1'($urandom_range(0, 1));
        tick();
        seen = penable_o;
      end
      check("transfer_start", 32'(seen), 1);
      if (!seen) begin
        m_en[0] = 1'b0;
        m_en[1] = 1'b0;
        pready_i = 1'b0;
        return;
      end
      check("grant", 32'(grant_o), 32'(eg));
      check("paddr", 32'(paddr_o), 32'(ea));
      check("pwrite", 32'(pwrite_o), 32'(ew));
      check("pwdata", 32'(pwdata_o), 32'(ewd));
      // Owner changes its inputs mid-transfer; slave side must not follow.
      m_addr[w]  = ~m_addr[w];
      m_wdata[w] = ~m_wdata[w];
      m_wr[w]    = ~m_wr[w];
      if (lat_fix > 0) lat = lat_fix;
      else begin
        case ($urandom_range(0, 19))
          0:       lat = TO + 1;
          1:       lat = TO;
          default: lat = int'($urandom_range(1, 5));
        endcase
      end
      rd = (rd_fix >= 0) ? rd_fix[DW-1:0] : DW'($urandom);
      er = (lat_fix > 0) ? 1'b0 : ($urandom_range(0, 3) == 0);
      e.m    = w[0];
      e.data = (lat > TO) ? '0 : (ew ? '0 : rd);
      e.err  = (lat > TO) ? 1'b1 : er;
      sb.push_back(e);
      stable = 1'b1;
      for (int c = 1; c <= TO && c <= lat; c++) begin
        if (paddr_o !== ea || pwrite_o !== ew || pwdata_o !== ewd || penable_o !== 1'b1 ||
            grant_o !== eg) stable = 1'b0;
        pready_i = (c == lat);
        prdata_i = (c == lat) ? rd : DW'($urandom);
        perror_i = (c == lat) ? er : 1'($urandom_range(0, 1));
        tick();
      end
      pready_i = 1'b0;
      check("busy_stable", 32'(stable), 1);
      check("resp_pready", 32'((w == 1) ? m1_pready_o : m0_pready_o), 1);
      check("resp_penable", 32'(penable_o), 0);
      rr_last = w[0];
      rem[w]--;
      if (rem[w] > 0) randomize_req(w);
      else m_en[w] = 1'b0;
    end
    pready_i = 1'b0;
  endtask

  // Monitor: checks every completion against the scoreboard and the held data.
  initial begin
    logic [DW-1:0] held [2];
    exp_t          e;
    held[0] = '0;
    held[1] = '0;
    forever begin
      @(negedge pclk);
      if (prst) begin
        held[0] = '0;
        held[1] = '0;
      end else if (!done) begin
        check("perror_without_pready",
              32'({m1_perror_o & ~m1_pready_o, m0_perror_o & ~m0_pready_o}), 0);
        if (m0_pready_o || m1_pready_o) begin
          if (sb.size() == 0) begin
            check("unexpected_pready", 32'({m1_pready_o, m0_pready_o}), 0);
          end else begin
            e = sb.pop_front();
            check("pready_owner", 32'({m1_pready_o, m0_pready_o}), e.m ? 2 : 1);
            check("prdata", 32'(e.m ? m1_prdata_o : m0_prdata_o), 32'(e.data));
            check("perror", 32'(e.m ? m1_perror_o : m0_perror_o), 32'(e.err));
            held[e.m] = e.data;
          end
        end
        check("m0_prdata_hold", 32'(m0_prdata_o), 32'(held[0]));
        check("m1_prdata_hold", 32'(m1_prdata_o), 32'(held[1]));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // Driver: directed cases first, then randomized batches.
  initial begin
    bit seen;
    prst     = 1'b1;
    pready_i = 1'b0;
    prdata_i = '0;
    perror_i = 1'b0;
    for (int m = 0; m < 2; m++) begin
      m_addr[m]  = '0;
      m_wr[m]    = 1'b0;
      m_wdata[m] = '0;
      m_en[m]    = 1'b0;
    end
    repeat (3) tick();
    check("reset_slave_side", 32'({paddr_o, pwrite_o, pwdata_o, penable_o, grant_o}), 0);
    check("reset_requester_side",
          32'({m0_prdata_o, m1_prdata_o, m0_pready_o, m1_pready_o, m0_perror_o, m1_perror_o}), 0);
    prst = 1'b0;

    // Simultaneous held requests: grants alternate starting with m0.
    randomize_req(0);
    randomize_req(1);
    run_batch(2, 2, 0, -1);

    // m0 write 0x20 = 0xA5, slave answers after 3 cycles.
    m_addr[0] = 8'h20; m_wr[0] = 1'b1; m_wdata[0] = 8'hA5;
    run_batch(1, 0, 3, 8'h77);

    // m0 read to give it non-zero held data, then m1 read 0x13 -> 0x5C.
    m_addr[0] = 8'h40; m_wr[0] = 1'b0; m_wdata[0] = 8'h00;
    run_batch(1, 0, 1, 8'h3C);
    m_addr[1] = 8'h13; m_wr[1] = 1'b0; m_wdata[1] = 8'h00;
    run_batch(0, 1, 2, 8'h5C);

    // Slave never answers: timeout completion with error and zero data.
    m_addr[0] = 8'h07; m_wr[0] = 1'b0;
    run_batch(1, 0, TO + 1, 8'hEE);

    // pready_i on the timeout cycle: normal completion.
    m_addr[1] = 8'h31; m_wr[1] = 1'b0;
    run_batch(0, 1, TO, 8'h99);

    // Leave m0 as last-served, then reset mid-BUSY.
    randomize_req(0);
    run_batch(1, 0, 2, -1);
    randomize_req(0);
    m_en[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      seen = penable_o;
    end
    check("reset_test_start", 32'(seen), 1);
    tick();
    #2 prst = 1'b1;
    #1;
    check("reset_abort_penable_grant", 32'({penable_o, grant_o}), 0);
    check("reset_abort_outputs",
          32'({m0_prdata_o, m1_prdata_o, m0_pready_o, m1_pready_o, paddr_o}), 0);
    m_en[0] = 1'b0;
    rr_last = 1'b1;
    tick();
    prst = 1'b0;
    // Pointer back at m1, so a tie goes to m0.
    randomize_req(0);
    randomize_req(1);
    run_batch(1, 1, 0, -1);

    for (int b = 0; b < 40; b++) begin
      randomize_req(0);
      randomize_req(1);
      run_batch(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 0, -1);
    end

    repeat (3) tick();
    check("scoreboard_drained", 32'(sb.size()), 0);
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
